// File: rtl/bcd_display_scan.sv
// bcd_display_scan: samples asynchronous, ripple-prone BCD digits into the clk domain,
// filters short transients, and scans a multiplexed 7-segment display.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   bcd_in     packed BCD digits (digit 0 = [3:0]), asynchronous
//   blank_in   asynchronous blank request, 1 = display dark
//   seg        registered segments {g,f,e,d,c,b,a}, active-high
//   dig_sel    registered one-hot digit enable, active-high
//   latched    registered filtered snapshot of bcd_in
//   scan_tick  one-cycle pulse in the last cycle of each digit slot
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, digit i>0 shows no segments if it and every higher digit are zero.
module bcd_display_scan #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    blank_in,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] latched,
  output logic                    scan_tick
);

  localparam int unsigned BusW = 4 * NUM_DIGITS;
  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(NUM_DIGITS - 1);

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b1000000;
    endcase
    return s;
  endfunction

  logic [BusW-1:0]       bcd_s1_q, bcd_s1_d;
  logic [BusW-1:0]       bcd_s2_q, bcd_s2_d;
  logic [BusW-1:0]       bcd_s3_q, bcd_s3_d;
  logic                  blank_s1_q, blank_s1_d;
  logic                  blank_s2_q, blank_s2_d;
  logic [BusW-1:0]       latched_q, latched_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;

  logic [3:0]            cur_digit;
  logic [NUM_DIGITS-1:0] cur_onehot;
  logic [6:0]            cur_seg;
`ifdef LEADING_ZERO_BLANK_EN
  logic                  hi_zero;
  logic                  cur_lz;
`endif

  always_comb begin
    bcd_s1_d   = bcd_in;
    bcd_s2_d   = bcd_s1_q;
    bcd_s3_d   = bcd_s2_q;
    blank_s1_d = blank_in;
    blank_s2_d = blank_s1_q;

    // Only a value seen on two consecutive samples is accepted; ripple never settles that long.
    latched_d = (bcd_s2_q == bcd_s3_q) ? bcd_s2_q : latched_q;

    scan_tick = (cnt_q == CntMax);
    cnt_d     = scan_tick ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (scan_tick) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end

    cur_digit  = '0;
    cur_onehot = '0;
`ifdef LEADING_ZERO_BLANK_EN
    hi_zero = 1'b1;
    cur_lz  = 1'b0;
`endif
    // Walk from the MSD down so hi_zero covers digit i and everything above it.
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
`ifdef LEADING_ZERO_BLANK_EN
      hi_zero = hi_zero & (latched_q[4*i +: 4] == 4'd0);
`endif
      if (idx_q == IdxW'(i)) begin
        cur_digit     = latched_q[4*i +: 4];
        cur_onehot[i] = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        cur_lz = hi_zero && (i != 0);
`endif
      end
    end

    cur_seg = decode(cur_digit);
`ifdef LEADING_ZERO_BLANK_EN
    if (cur_lz) begin
      cur_seg = '0;
    end
`endif

    // The cycle after scan_tick is dark so the old digit never ghosts onto the new anode.
    if (scan_tick || blank_s2_q) begin
      seg_d     = '0;
      dig_sel_d = '0;
    end else begin
      seg_d     = cur_seg;
      dig_sel_d = cur_onehot;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcd_s1_q   <= '0;
      bcd_s2_q   <= '0;
      bcd_s3_q   <= '0;
      blank_s1_q <= 1'b0;
      blank_s2_q <= 1'b0;
      latched_q  <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      seg_q      <= '0;
      dig_sel_q  <= '0;
    end else begin
      bcd_s1_q   <= bcd_s1_d;
      bcd_s2_q   <= bcd_s2_d;
      bcd_s3_q   <= bcd_s3_d;
      blank_s1_q <= blank_s1_d;
      blank_s2_q <= blank_s2_d;
      latched_q  <= latched_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      dig_sel_q  <= dig_sel_d;
    end
  end

  assign seg     = seg_q;
  assign dig_sel = dig_sel_q;
  assign latched = latched_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with NUM_DIGITS=4, SCAN_DIV=4.
module tb_bcd_display_scan;

  logic        clk;
  logic        rst;
  logic [15:0] bcd_in;
  logic        blank_in;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic [15:0] latched;
  logic        scan_tick;

  int n_cmp  = 0;
  int n_fail = 0;
  int edges  = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LzSeg = 7'b0000000;
`else
  localparam logic [6:0] LzSeg = 7'b0111111;
`endif

  bcd_display_scan #(
    .NUM_DIGITS(4),
    .SCAN_DIV  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bcd_in   (bcd_in),
    .blank_in (blank_in),
    .seg      (seg),
    .dig_sel  (dig_sel),
    .latched  (latched),
    .scan_tick(scan_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic        blank;
    logic [3:0]  dig;
    logic [6:0]  seg;
    logic        tick;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic [15:0] b, logic bl, logic [3:0] d, logic [6:0] s, logic t);
    vec_t v;
    v.bcd = b; v.blank = bl; v.dig = d; v.seg = s; v.tick = t;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  // Expected dig_sel after edge k counted from reset release (SCAN_DIV=4, 4 digits).
  function automatic logic [3:0] exp_dig(int k);
    int pre;
    pre = k - 1;
    if ((pre % 4) == 3) return 4'b0000;
    return 4'b0001 << ((pre / 4) % 4);
  endfunction

  task automatic wait_sel(input logic [3:0] want, input string name);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 40 && !hit; n++) begin
      step();
      if (dig_sel === want) hit = 1'b1;
    end
    if (!hit) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: dig_sel never reached %b (last %b)", name, want, dig_sel);
    end
  endtask

  initial begin
    int ticks;

    vecs[0]  = mk(16'h1234, 1'b0, 4'b0010, 7'b1001111, 1'b0);
    vecs[1]  = mk(16'h1234, 1'b0, 4'b0010, 7'b1001111, 1'b0);
    vecs[2]  = mk(16'h1234, 1'b0, 4'b0010, 7'b1001111, 1'b1);
    vecs[3]  = mk(16'h1234, 1'b0, 4'b0000, 7'b0000000, 1'b0);
    vecs[4]  = mk(16'h1234, 1'b0, 4'b0100, 7'b1011011, 1'b0);
    vecs[5]  = mk(16'h1234, 1'b0, 4'b0100, 7'b1011011, 1'b0);
    vecs[6]  = mk(16'h1234, 1'b0, 4'b0100, 7'b1011011, 1'b1);
    vecs[7]  = mk(16'h1234, 1'b0, 4'b0000, 7'b0000000, 1'b0);
    vecs[8]  = mk(16'h1234, 1'b0, 4'b1000, 7'b0000110, 1'b0);
    vecs[9]  = mk(16'h1234, 1'b0, 4'b1000, 7'b0000110, 1'b0);
    vecs[10] = mk(16'h1234, 1'b0, 4'b1000, 7'b0000110, 1'b1);
    vecs[11] = mk(16'h1234, 1'b0, 4'b0000, 7'b0000000, 1'b0);
    vecs[12] = mk(16'h1234, 1'b0, 4'b0001, 7'b1100110, 1'b0);
    vecs[13] = mk(16'h1234, 1'b0, 4'b0001, 7'b1100110, 1'b0);
    vecs[14] = mk(16'h1234, 1'b0, 4'b0001, 7'b1100110, 1'b1);
    vecs[15] = mk(16'h1234, 1'b0, 4'b0000, 7'b0000000, 1'b0);

    // Reset held with live input
    rst = 1'b0; bcd_in = 16'h9999; blank_in = 1'b0;
    step(); step(); step();
    check("rst_seg", 32'(seg), 32'h0);
    check("rst_dig", 32'(dig_sel), 32'h0);
    check("rst_latched", 32'(latched), 32'h0);
    check("rst_tick", 32'(scan_tick), 32'h0);

    rst = 1'b1; edges = 0;
    step();
    check("rel_dig_first", 32'(dig_sel), 32'h1);
    step(); step();
    check("rel_latched_e3", 32'(latched), 32'h0);
    step();
    check("rel_latched_e4", 32'(latched), 32'h9999);
    step();

    // Asynchronous reset between clock edges
    #3 rst = 1'b0;
    #1;
    check("async_latched", 32'(latched), 32'h0);
    check("async_dig", 32'(dig_sel), 32'h0);
    check("async_tick", 32'(scan_tick), 32'h0);

    // Scan with a stable value: restart from reset so slot phase is known
    bcd_in = 16'h1234;
    step(); step();
    rst = 1'b1; edges = 0;
    step(); step(); step(); step();
    check("scan_latched", 32'(latched), 32'h1234);
    for (int i = 0; i < 16; i++) begin
      bcd_in = vecs[i].bcd; blank_in = vecs[i].blank;
      step();
      check($sformatf("scan_dig[%0d]", i), 32'(dig_sel), 32'(vecs[i].dig));
      check($sformatf("scan_seg[%0d]", i), 32'(seg), 32'(vecs[i].seg));
      check($sformatf("scan_tick[%0d]", i), 32'(scan_tick), 32'(vecs[i].tick));
    end

    // Ripple filter
    bcd_in = 16'h0000;
    step(); step(); step(); step();
    check("rip_zero", 32'(latched), 32'h0);
    for (int i = 0; i < 20; i++) begin
      bcd_in = (i % 2 == 0) ? 16'h0008 : 16'h0007;
      step();
      check($sformatf("rip_hold[%0d]", i), 32'(latched), 32'h0);
    end
    bcd_in = 16'h0008;
    step(); step(); step();
    check("rip_e3", 32'(latched), 32'h0);
    step();
    check("rip_e4", 32'(latched), 32'h0008);

    // Invalid code shows a dash
    bcd_in = 16'h000A;
    step(); step(); step(); step();
    check("inv_latched", 32'(latched), 32'h000A);
    wait_sel(4'b0001, "inv_wait");
    check("inv_seg", 32'(seg), 32'b1000000);

    // Blank: display dark, scan keeps going, resumes in phase
    blank_in = 1'b1;
    step(); step(); step();
    check("blk_dig", 32'(dig_sel), 32'h0);
    check("blk_seg", 32'(seg), 32'h0);
    ticks = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (scan_tick) ticks++;
      check($sformatf("blk_dark[%0d]", i), 32'({dig_sel, seg}), 32'h0);
    end
    check("blk_ticks", 32'(ticks), 32'd2);
    blank_in = 1'b0;
    step(); step(); step();
    check("blk_resume0", 32'(dig_sel), 32'(exp_dig(edges)));
    step();
    check("blk_resume1", 32'(dig_sel), 32'(exp_dig(edges)));

    // Leading zeros
    bcd_in = 16'h0050;
    step(); step(); step(); step();
    wait_sel(4'b1000, "lz_w3");
    check("lz_d3", 32'(seg), 32'(LzSeg));
    wait_sel(4'b0001, "lz_w0");
    check("lz_d0", 32'(seg), 32'b0111111);
    wait_sel(4'b0010, "lz_w1");
    check("lz_d1", 32'(seg), 32'b1101101);
    wait_sel(4'b0100, "lz_w2");
    check("lz_d2", 32'(seg), 32'(LzSeg));

    bcd_in = 16'h0000;
    step(); step(); step(); step();
    wait_sel(4'b0001, "z_w0");
    check("z_d0", 32'(seg), 32'b0111111);
    wait_sel(4'b1000, "z_w3");
    check("z_d3", 32'(seg), 32'(LzSeg));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
Downstream consumer of the ripple BCD counter stage. Samples NUM_DIGITS asynchronous, glitch-prone BCD digits into the system clock domain, filters ripple transients, and drives a time-multiplexed 7-segment display: one-hot digit select plus decoded segments. Sits between the counter chain and the board display pins.

Parameters:
NUM_DIGITS, 4, number of BCD digits; range 1 to 8.
SCAN_DIV, 1000, clk cycles per digit slot; minimum 2.

Ports:
clk  input  1  system clock; rising edge.
rst  input  1  reset, asynchronous, active-low.
bcd_in  input  4*NUM_DIGITS  packed BCD digits, asynchronous; digit 0 (LSD) = [3:0].
blank_in  input  1  asynchronous display blank request; 1 = display off.
seg  output  7  segments {g,f,e,d,c,b,a}; active-high; registered.
dig_sel  output  NUM_DIGITS  one-hot digit enable; active-high; registered.
latched  output  4*NUM_DIGITS  filtered snapshot of bcd_in; registered.
scan_tick  output  1  one-cycle pulse at the end of each digit slot.

Behaviour:
- Reset (rst=0) clears immediately: seg=0, dig_sel=0, latched=0, scan_tick=0, prescaler=0, digit index=0, and all sync flops=0. Reset mid-scan takes effect at once; no partial frame completes.
- Capture: each bit of bcd_in and blank_in goes through 2 sync flops (s1, s2), then a third flop s3. When s2==s3 across the whole bus, latched<=s2; otherwise latched holds. A stable input change is visible on latched after the 4th rising edge. Any toggle that lasts less than 2 consecutive samples never reaches latched.
- Prescaler: counts 0 to SCAN_DIV-1, then wraps. scan_tick=1 in the cycle the count equals SCAN_DIV-1, and 0 otherwise.
- Digit index: increments on scan_tick and wraps from NUM_DIGITS-1 to 0.
- Outputs (registered, 1 cycle behind index):
  - dig_sel = one-hot(index).
  - seg = decode(latched digit[index]).
- Anti-ghost: in the cycle after scan_tick, seg=0 and dig_sel=0, so each slot has SCAN_DIV-1 lit cycles.
- Decode table:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - codes 10 to 15 = 1000000 (dash)
- Blank: while synchronized blank_in=1, seg=0 and dig_sel=0. Prescaler, index, scan_tick and latched keep running. Release resumes on the current index with no resync.
- Simultaneous latched update and slot change: the new slot decodes the value latched in the same edge's previous state. Display catches up within 1 cycle; no extra delay.
- Synchronous deassertion of rst is handled by the integrator's reset synchronizer; not required inside this block.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: digit i>0 shows seg=0 when latched digit i and all higher digits are 0. dig_sel still asserts. Digit 0 is never blanked.
- Undefined: all digits are decoded normally, including leading zeros.

Test Plan:
1. Reset:
   - Hold rst=0 with bcd_in=16'h9999 -> seg=0, dig_sel=0, latched=0, scan_tick=0.
   - Release -> latched=16'h9999 after 4 edges; dig_sel=0001.
2. Scan (SCAN_DIV=4, bcd_in=16'h1234 stable):
   - dig_sel steps 0001, 0010, 0100, 1000, then wraps to 0001; each slot is 3 lit cycles plus 1 dark cycle.
   - seg per slot: 1100110, 1001111, 1011011, 0000110.
   - scan_tick is high every 4th cycle.
3. Ripple filter:
   - bcd_in alternates 16'h0007 and 16'h0008 every clk for 20 cycles -> latched stays 16'h0000.
   - Then hold 16'h0008 -> latched=16'h0008 exactly 4 edges later.
4. Invalid code: bcd_in=16'h000A -> digit-0 slot seg=1000000.
5. Blank:
   - blank_in=1 -> seg=0 and dig_sel=0 within 3 edges, while scan_tick continues.
   - blank_in=0 -> display resumes at the current index.
6. LEADING_ZERO_BLANK_EN, bcd_in=16'h0050:
   - Defined: digits 3 and 2 seg=0, digit 1 seg=1101101, digit 0 seg=0111111. With bcd_in=16'h0000, only digit 0 shows 0111111.
   - Undefined: digits 3 and 2 show 0111111.
